// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Consumers: bin_bcd_seq, bcd_add3.
`timescale 1ns/1ps
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Smallest digit count d with 10^d > 2^bin_w.
  function automatic int min_digits(input int bin_w);
    logic [255:0] pow2;
    logic [255:0] p10;
    int           d;
    pow2 = 256'd1 << bin_w;
    p10  = 256'd1;
    d    = 0;
    while (p10 <= pow2) begin
      p10 = p10 * 256'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
// Purely combinational, one instance per BCD digit.
`timescale 1ns/1ps
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_bcd_seq.sv
// Iterative double-dabble converter, one bit per cycle, result held.
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
`timescale 1ns/1ps
module bin_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_chk
    $error("bin_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [SW-1:0]    scr_q, scr_d;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic             valid_q, valid_d;

  logic [SW-1:0]       adj;
  logic [SW+BIN_W-1:0] sh;
  logic [SW-1:0]       res;
  logic                lz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scr_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  always_comb begin
    sh = {adj, bin_q} << 1;
    res = sh[SW+BIN_W-1:BIN_W];
    lz = 1'b1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz = lz && (res[4*i +: 4] == 4'd0);
      if (lz) res[4*i +: 4] = BCD_BLANK;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = sh[SW+BIN_W-1:BIN_W];
        bin_d = sh[BIN_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          bcd_d   = res;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign bcd_out = bcd_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_bin_bcd_seq;

  localparam int BIN_W  = 24;
  localparam int DIGITS = 8;
  localparam int LAT    = 24;

  logic              clk;
  logic              rst;
  logic [BIN_W-1:0]  bin_in;
  logic              start;
  logic              ready;
  logic [31:0]       bcd_out;
  logic              valid;

  int ntests = 0;
  int nfail  = 0;
  int vcnt   = 0;
  logic [31:0] sb[$];
  time t0;

  bin_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .ready   (ready),
    .bcd_out (bcd_out),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_of(input int unsigned n);
    logic [31:0] r;
    int unsigned v;
    bit z;
    v = n;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && (r[4*i +: 4] == 4'd0);
      if (z) r[4*i +: 4] = 4'hF;
    end
`else
    z = 1'b0;
`endif
    return r;
  endfunction

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst === 1'b1 && valid === 1'b1) begin
      vcnt++;
      ntests++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_valid bcd_out=%h", bcd_out);
      end else begin
        e = sb.pop_front();
        if (bcd_out !== e) begin
          nfail++;
          $display("FAIL result got=%h exp=%h", bcd_out, e);
        end
      end
    end
  end

  task automatic start_conv(input int unsigned v);
    int k;
    k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    bin_in = BIN_W'(v);
    start  = 1'b1;
    @(posedge clk);
    t0 = $time;
    sb.push_back(exp_of(v));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output time tv);
    ok = 1'b0;
    tv = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        tv = $time;
        break;
      end
    end
    if (!ok) begin
      ntests++;
      nfail++;
      $display("FAIL valid_timeout got=none exp=pulse");
    end
  endtask

  task automatic check_lat(input time tv);
    time lat;
    lat = (tv - 5 - t0) / 10;
    ntests++;
    if (lat !== LAT) begin
      nfail++;
      $display("FAIL latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    ntests++;
    if (ready !== 1'b1 || valid !== 1'b0 || bcd_out !== 32'h0) begin
      nfail++;
      $display("FAIL reset_state got=%b%b%h exp=10%h",
               ready, valid, bcd_out, 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    bit ok;
    time tv;
    start_conv(0);
    ntests++;
    if (ready !== 1'b0) begin
      nfail++;
      $display("FAIL busy_ready got=%b exp=0", ready);
    end
    wait_valid(ok, tv);
    if (ok) check_lat(tv);
    ntests++;
    if (ready !== 1'b1) begin
      nfail++;
      $display("FAIL ready_return got=%b exp=1", ready);
    end
  endtask

  task automatic test_max();
    bit ok;
    time tv;
    start_conv(16777215);
    wait_valid(ok, tv);
    if (ok) check_lat(tv);
    @(negedge clk);
    ntests++;
    if (valid !== 1'b0) begin
      nfail++;
      $display("FAIL pulse_width got=%b exp=0", valid);
    end
  endtask

  task automatic test_hold();
    bit ok;
    time tv;
    logic [31:0] e;
    e = exp_of(1234);
    start_conv(1234);
    wait_valid(ok, tv);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bin_in = BIN_W'($urandom);
      ntests++;
      if (bcd_out !== e) begin
        nfail++;
        $display("FAIL hold got=%h exp=%h", bcd_out, e);
      end
    end
  endtask

  task automatic test_ignored_start();
    bit ok;
    time tv;
    int v0;
    start_conv(500);
    repeat (4) @(negedge clk);
    bin_in = BIN_W'(777);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    v0 = vcnt;
    wait_valid(ok, tv);
    repeat (40) @(negedge clk);
    ntests++;
    if (vcnt - v0 !== 1) begin
      nfail++;
      $display("FAIL ignored_start got=%0d exp=1", vcnt - v0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    time tv;
    int v0;
    start_conv(999999);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ntests++;
    if (bcd_out !== 32'h0 || ready !== 1'b1 || valid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid got=%h/%b/%b exp=0/1/0",
               bcd_out, ready, valid);
    end
    sb.delete();
    v0 = vcnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    ntests++;
    if (vcnt !== v0) begin
      nfail++;
      $display("FAIL reset_no_valid got=%0d exp=0", vcnt - v0);
    end
    start_conv(99);
    wait_valid(ok, tv);
    if (ok) check_lat(tv);
  endtask

  task automatic test_back_to_back();
    bit ok;
    time tv;
    time tp;
    @(negedge clk);
    bin_in = BIN_W'(10);
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
    tp = 0;
    for (int k = 0; k < 3; k++) sb.push_back(exp_of(10));
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok, tv);
      if (!ok) break;
      if (k == 2) start = 1'b0;
      if (k > 0) begin
        ntests++;
        if (tv - tp !== 250) begin
          nfail++;
          $display("FAIL b2b_period got=%0t exp=250", tv - tp);
        end
      end else begin
        check_lat(tv);
      end
      tp = tv;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    ntests++;
    if (sb.size() !== 0) begin
      nfail++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_hold();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
